// File: rtl/dmi_initiator.sv
// dmi_initiator: DTM-side master of the debug-module interface.
// Turns access words captured by the JTAG TAP into DMI request/response
// transactions, tracks the sticky DMI error and builds the capture word.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   access_valid_i          one-cycle pulse: new access word from the TAP
//   access_op_i/addr_i/data_i  access op (0 NOP,1 READ,2 WRITE,3 rsvd), addr, wdata
//   dmireset_i              pulse: clear sticky error
//   dmihardreset_i          pulse: abort transaction, clear all state
//   dmi_req_o/_valid_o/_ready_i    request channel {dm_sel, addr, op, data}
//   dmi_resp_i/_valid_i/_ready_o   response channel {data, resp}
//   capture_o               {addr[6:0], data[31:0], status[1:0]} for the TAP
//   busy_o                  transaction in flight
module dmi_initiator #(
  parameter logic [5:0]  DmSel         = 6'h0,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        access_valid_i,
  input  logic [1:0]  access_op_i,
  input  logic [6:0]  access_addr_i,
  input  logic [31:0] access_data_i,
  input  logic        dmireset_i,
  input  logic        dmihardreset_i,
  output logic [46:0] dmi_req_o,
  output logic        dmi_req_valid_o,
  input  logic        dmi_req_ready_i,
  input  logic [33:0] dmi_resp_i,
  input  logic        dmi_resp_valid_i,
  output logic        dmi_resp_ready_o,
  output logic [40:0] capture_o,
  output logic        busy_o
);

  // Counter width; kept at least one bit so a disabled timeout still elaborates.
  localparam int unsigned CntW = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);

  localparam logic [1:0] DTM_SUCCESS = 2'd0;
  localparam logic [1:0] DTM_FAILED  = 2'd2;
  localparam logic [1:0] DTM_BUSY    = 2'd3;

  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  typedef struct packed {
    logic [5:0]  dm_sel;
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e          state_q;
  dmi_req_t        req_q;
  logic [1:0]      sticky_q;
  logic [6:0]      cap_addr_q;
  logic [31:0]     cap_data_q;
  logic [CntW-1:0] cnt_q;

  dmi_resp_t       resp;
  logic [CntW:0]   cnt_inc;
  logic            req_hs;
  logic            resp_done;
  logic            timeout_hit;
  logic            abort;
  logic            start;
  logic [1:0]      err_base;
  logic [1:0]      sticky_d;
  logic [1:0]      status_c;

  assign resp      = dmi_resp_t'(dmi_resp_i);
  assign req_hs    = (state_q == REQ) && dmi_req_valid_o && dmi_req_ready_i;
  assign resp_done = (state_q == WAIT) && dmi_resp_ready_o && dmi_resp_valid_i;
  assign cnt_inc   = {1'b0, cnt_q} + (CntW+1)'(1);

  // Limit reached at the end of the TimeoutCycles-th busy cycle.
  assign timeout_hit = (TimeoutCycles != 0) && (cnt_inc >= (CntW+1)'(TimeoutCycles));

  // A request handshake or response completion in the limit cycle wins.
  assign abort = timeout_hit &&
                 (((state_q == REQ) && !req_hs) || ((state_q == WAIT) && !resp_done));

  assign start = (state_q == IDLE) && access_valid_i && (err_base == DTM_SUCCESS) &&
                 ((access_op_i == OP_READ) || (access_op_i == OP_WRITE));

  // Sticky error: dmireset first, then access evaluation, then completion/timeout.
  always_comb begin
    err_base = dmireset_i ? DTM_SUCCESS : sticky_q;
    sticky_d = err_base;
    if (access_valid_i) begin
      if (state_q != IDLE) begin
        if (err_base == DTM_SUCCESS) sticky_d = DTM_BUSY;
      end else if ((err_base == DTM_SUCCESS) && (access_op_i == OP_RSVD)) begin
        sticky_d = DTM_FAILED;
      end
    end
    if (resp_done) begin
      if (resp.resp != DTM_SUCCESS) sticky_d = resp.resp;
    end else if (abort) begin
      sticky_d = DTM_FAILED;
    end
  end

  // Transaction FSM with registered handshake outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= IDLE;
      req_q            <= '{dm_sel: DmSel, addr: 7'h0, op: 2'h0, data: 32'h0};
      dmi_req_valid_o  <= 1'b0;
      dmi_resp_ready_o <= 1'b0;
      busy_o           <= 1'b0;
      sticky_q         <= DTM_SUCCESS;
      cap_addr_q       <= 7'h0;
      cap_data_q       <= 32'h0;
      cnt_q            <= '0;
    end else if (dmihardreset_i) begin
      state_q          <= IDLE;
      dmi_req_valid_o  <= 1'b0;
      dmi_resp_ready_o <= 1'b0;
      busy_o           <= 1'b0;
      sticky_q         <= DTM_SUCCESS;
      cnt_q            <= '0;
    end else begin
      sticky_q <= sticky_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            req_q           <= '{dm_sel: DmSel, addr: access_addr_i,
                                 op: access_op_i, data: access_data_i};
            cap_addr_q      <= access_addr_i;
            cnt_q           <= '0;
            dmi_req_valid_o <= 1'b1;
            busy_o          <= 1'b1;
            state_q         <= REQ;
          end
        end
        REQ: begin
          if (req_hs) begin
            cnt_q            <= CntW'(cnt_inc);
            dmi_req_valid_o  <= 1'b0;
            dmi_resp_ready_o <= 1'b1;
            state_q          <= WAIT;
          end else if (abort) begin
            dmi_req_valid_o <= 1'b0;
            busy_o          <= 1'b0;
            state_q         <= IDLE;
          end else begin
            cnt_q <= CntW'(cnt_inc);
          end
        end
        WAIT: begin
          if (resp_done) begin
            cap_data_q       <= resp.data;
            dmi_resp_ready_o <= 1'b0;
            busy_o           <= 1'b0;
            state_q          <= IDLE;
          end else if (abort) begin
            dmi_resp_ready_o <= 1'b0;
            busy_o           <= 1'b0;
            state_q          <= IDLE;
          end else begin
            cnt_q <= CntW'(cnt_inc);
          end
        end
        default: begin
          dmi_req_valid_o  <= 1'b0;
          dmi_resp_ready_o <= 1'b0;
          busy_o           <= 1'b0;
          state_q          <= IDLE;
        end
      endcase
    end
  end

  // Capture status: sticky error, else BUSY while a transaction is active.
  always_comb begin
    status_c = DTM_SUCCESS;
    if (sticky_q != DTM_SUCCESS) status_c = sticky_q;
    else if (state_q != IDLE)    status_c = DTM_BUSY;
  end

  assign dmi_req_o = req_q;
  assign capture_o = {cap_addr_q, cap_data_q, status_c};

endmodule
